// File: rtl/mips_shift_pkg.sv
`default_nettype none
// ============================================================================
// Module  : mips_shift_pkg
// Purpose : Shared definitions for the multi-cycle shift sequencer:
//           shift operation encodings and the sequencer state type.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package mips_shift_pkg;

   // Shift operation encodings as presented on the op input
   localparam logic [1:0] OP_SLL  = 2'b00;
   localparam logic [1:0] OP_SRL  = 2'b01;
   localparam logic [1:0] OP_SRA  = 2'b10;
   localparam logic [1:0] OP_RSVD = 2'b11;

   // Sequencer state
   typedef enum logic [0:0] {
      S_IDLE  = 1'b0,
      S_SHIFT = 1'b1
   } state_t;

endpackage : mips_shift_pkg
`default_nettype wire

// File: rtl/shift_step.sv
`default_nettype none
// ============================================================================
// Module  : shift_step
// Purpose : Single-step shift stage. Shifts data by 1 (or by 4 when amt4
//           is set) in the direction and fill mode selected by op.
// Ports   : data    - value to shift
//           op      - OP_SLL / OP_SRL / OP_SRA; OP_RSVD passes data through
//           amt4    - 0: shift by 1, 1: shift by 4
//           shifted - shifted value
// Revision: 1.0 - initial release
// ============================================================================
module shift_step
   import mips_shift_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] data,
   input  logic [1:0]       op,
   input  logic             amt4,
   output logic [WIDTH-1:0] shifted
);

   always_comb begin
      shifted = data;
      case (op)
         OP_SLL:  shifted = amt4 ? (data << 4) : (data << 1);
         OP_SRL:  shifted = amt4 ? (data >> 4) : (data >> 1);
         OP_SRA:  shifted = amt4 ? ($signed(data) >>> 4) : ($signed(data) >>> 1);
         default: shifted = data;
      endcase
   end

endmodule : shift_step
`default_nettype wire

// File: rtl/shift_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : shift_sequencer
// Purpose : Multi-cycle SLL/SRL/SRA controller. Loads operand and shift
//           amount on start, iterates a single-step shift stage until the
//           count reaches zero, then presents the result with a one-cycle
//           done pulse.
// Ports   : clk     - system clock, rising edge
//           reset   - asynchronous active-high reset
//           start   - shift request, sampled only when idle
//           flush   - synchronous abort of the operation in progress
//           op      - 00 SLL, 01 SRL, 10 SRA, 11 reserved (pass-through)
//           operand - value to shift, sampled with start
//           shamt   - shift amount, sampled with start
//           busy    - high while an operation is in flight
//           done    - one-cycle pulse when result is valid
//           result  - shifted value, held until the next done
// Config  : SHIFT_SEQ_FAST4_EN - when defined, steps by 4 while at least 4
//           positions remain, otherwise by 1. Results are identical.
// Revision: 1.0 - initial release
// ============================================================================
module shift_sequencer
   import mips_shift_pkg::*;
#(
   parameter int WIDTH   = 32,
   parameter int SHAMT_W = 5
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic               flush,
   input  logic [1:0]         op,
   input  logic [WIDTH-1:0]   operand,
   input  logic [SHAMT_W-1:0] shamt,
   output logic               busy,
   output logic               done,
   output logic [WIDTH-1:0]   result
);

   state_t             state;
   state_t             state_nxt;
   logic [WIDTH-1:0]   shift_reg;
   logic [SHAMT_W-1:0] count;
   logic [1:0]         op_r;
   logic [WIDTH-1:0]   step_out;
   logic               use4;
   logic [SHAMT_W-1:0] step_amt;
   logic               accept;

   // A request is dropped if flush arrives in the same cycle
   assign accept = start && !flush;

`ifdef SHIFT_SEQ_FAST4_EN
   assign use4     = (count >= SHAMT_W'(4));
   assign step_amt = use4 ? SHAMT_W'(4) : SHAMT_W'(1);
`else
   assign use4     = 1'b0;
   assign step_amt = SHAMT_W'(1);
`endif

   shift_step #(
      .WIDTH (WIDTH)
   ) u_shift_step (
      .data    (shift_reg),
      .op      (op_r),
      .amt4    (use4),
      .shifted (step_out)
   );

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (accept) state_nxt = S_SHIFT;
         S_SHIFT: if (flush || (count == '0)) state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Output logic: done is registered below, so busy and done are exclusive
   always_comb begin
      busy = (state == S_SHIFT);
   end

   // Datapath: operand/count load, iteration, result capture
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         shift_reg <= '0;
         count     <= '0;
         op_r      <= OP_SLL;
         result    <= '0;
         done      <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (accept) begin
                  shift_reg <= operand;
                  // Reserved op behaves as a zero-length shift
                  count     <= (op == OP_RSVD) ? '0 : shamt;
                  op_r      <= op;
               end
            end
            S_SHIFT: begin
               if (!flush) begin
                  if (count != '0) begin
                     shift_reg <= step_out;
                     count     <= count - step_amt;
                  end else begin
                     result <= shift_reg;
                     done   <= 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule : shift_sequencer
`default_nettype wire

// File: tb/tb_shift_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : tb_shift_sequencer
// Purpose : Self-checking bench for shift_sequencer. Issued requests push
//           the expected result and done time into a queue; a monitor pops
//           and compares on every done pulse.
// Revision: 1.0 - initial release
// ============================================================================
module tb_shift_sequencer;

   localparam int WIDTH   = 32;
   localparam int SHAMT_W = 5;

   typedef struct {
      logic [WIDTH-1:0] res;
      int               at_edge;
   } exp_t;

   logic               clk = 1'b0;
   logic               reset = 1'b1;
   logic               start = 1'b0;
   logic               flush = 1'b0;
   logic [1:0]         op = 2'b00;
   logic [WIDTH-1:0]   operand = '0;
   logic [SHAMT_W-1:0] shamt = '0;
   logic               busy;
   logic               done;
   logic [WIDTH-1:0]   result;

   exp_t             q[$];
   int               edge_n = 0;
   int               n_checks = 0;
   int               n_pass = 0;
   logic [WIDTH-1:0] last_exp = '0;

   shift_sequencer #(
      .WIDTH   (WIDTH),
      .SHAMT_W (SHAMT_W)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .start   (start),
      .flush   (flush),
      .op      (op),
      .operand (operand),
      .shamt   (shamt),
      .busy    (busy),
      .done    (done),
      .result  (result)
   );

   always #5 clk = ~clk;
   always @(posedge clk) edge_n <= edge_n + 1;

   function automatic void check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_checks++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
   endfunction

   // Reference: the whole shift in one arithmetic step
   function automatic logic [WIDTH-1:0] model(input logic [1:0] o, input logic [WIDTH-1:0] d,
                                              input int s);
      case (o)
         2'b00:   return d << s;
         2'b01:   return d >> s;
         2'b10:   return WIDTH'($signed(d) >>> s);
         default: return d;
      endcase
   endfunction

   // Edges from the sampling edge of start to the edge that raises done
   function automatic int latency(input logic [1:0] o, input int s);
      int n;
      n = (o == 2'b11) ? 0 : s;
`ifdef SHIFT_SEQ_FAST4_EN
      return n / 4 + n % 4 + 1;
`else
      return n + 1;
`endif
   endfunction

   // Called at a negedge with the sequencer idle (or in its done cycle)
   task automatic issue(input logic [1:0] o, input logic [WIDTH-1:0] d, input int s);
      exp_t e;
      op      = o;
      operand = d;
      shamt   = SHAMT_W'(s);
      start   = 1'b1;
      e.res     = model(o, d, s);
      e.at_edge = edge_n + 1 + latency(o, s);
      q.push_back(e);
      last_exp = e.res;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_idle(output int n);
      n = 0;
      while (busy && n < 200) begin
         n++;
         @(negedge clk);
      end
      if (n >= 200) check("wait_idle_timeout", 64'(n), 64'd0);
   endtask

   // Scoreboard monitor
   always @(negedge clk) begin
      if (!reset && done) begin
         if (q.size() == 0) begin
            check("unexpected_done", 64'(result), 64'hDEAD_BEEF_DEAD_BEEF);
         end else begin
            exp_t e;
            e = q.pop_front();
            check("result", 64'(result), 64'(e.res));
            check("done_time", 64'(edge_n), 64'(e.at_edge));
            check("busy_with_done", 64'(busy), 64'd0);
         end
      end
   end

   initial begin
      int n;
      // Reset state
      repeat (2) @(negedge clk);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      check("rst_result", 64'(result), 64'd0);
      reset = 1'b0;
      @(negedge clk);

      // Directed cases; each issue lands in the previous done cycle
      issue(2'b00, 32'h0000_000A, 2);
      wait_idle(n);
      check("sll2_busy_cycles", 64'(n), 64'(latency(2'b00, 2)));
      issue(2'b10, 32'h8000_0000, 4);  wait_idle(n);
      issue(2'b01, 32'h8000_0000, 4);  wait_idle(n);
      issue(2'b10, 32'h8000_0000, 31); wait_idle(n);
      issue(2'b00, 32'h1234_5678, 0);  wait_idle(n);
      issue(2'b11, 32'h1234_5678, 7);  wait_idle(n);

      // Start while busy is ignored
      issue(2'b01, 32'hF0F0_F0F0, 6);
      op = 2'b00; operand = 32'hFFFF_FFFF; shamt = 5'd3; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_idle(n);
      repeat (3) @(negedge clk);

      // Flush in the second shift cycle of a 10-bit shift
      begin
         logic [WIDTH-1:0] held;
         held = last_exp;
         op = 2'b00; operand = 32'h0000_0001; shamt = 5'd10; start = 1'b1;
         @(negedge clk);
         start = 1'b0;
         @(negedge clk);
         flush = 1'b1;
         @(negedge clk);
         flush = 1'b0;
         check("flush_busy", 64'(busy), 64'd0);
         check("flush_result_held", 64'(result), 64'(held));
         repeat (12) @(negedge clk);
         check("flush_result_still", 64'(result), 64'(held));
      end

      // Flush together with start in idle drops the request
      op = 2'b00; operand = 32'h0000_0003; shamt = 5'd1; start = 1'b1; flush = 1'b1;
      @(negedge clk);
      start = 1'b0; flush = 1'b0;
      check("flush_start_busy", 64'(busy), 64'd0);
      repeat (3) @(negedge clk);

      // Reset mid-operation
      issue(2'b00, 32'h0000_0001, 20);
      repeat (5) @(negedge clk);
      reset = 1'b1;
      #1;
      check("midrst_busy", 64'(busy), 64'd0);
      check("midrst_done", 64'(done), 64'd0);
      check("midrst_result", 64'(result), 64'd0);
      q.delete();
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      issue(2'b00, 32'h0000_0001, 1);
      wait_idle(n);

      // Randomized traffic, mixing back-to-back and gapped requests
      for (int i = 0; i < 150; i++) begin
         issue(2'($urandom_range(0, 3)), $urandom, int'($urandom_range(0, 31)));
         wait_idle(n);
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end

      // Drain
      n = 0;
      while (q.size() != 0 && n < 100) begin
         n++;
         @(negedge clk);
      end
      check("drain_empty", 64'(q.size()), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   // Global watchdog
   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1);
   end

endmodule : tb_shift_sequencer
`default_nettype wire

// File: doc/shift_sequencer.md
Name: shift_sequencer

Overview:
Multi-cycle shift controller for the MIPS datapath that executes SLL/SRL/SRA one bit per cycle using a single-step shift stage, instead of a full barrel shifter. It accepts a start request from the execute-stage control, holds busy while iterating, and returns the result with a one-cycle done pulse. It sits beside the ALU and sequences the shared shift datapath.

Parameters:
WIDTH, 32, data width of operand and result
SHAMT_W, 5, width of shift amount; must satisfy 2**SHAMT_W >= WIDTH

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  request a shift; sampled only in IDLE
flush  input  1  synchronous abort of the operation in progress
op  input  2  00 SLL, 01 SRL, 10 SRA, 11 reserved
operand  input  WIDTH  value to shift; sampled with start
shamt  input  SHAMT_W  shift amount; sampled with start
busy  output  1  high while an operation is in flight
done  output  1  one-cycle pulse when result is valid
result  output  WIDTH  shifted value; held until the next done

Behaviour:
- Reset (async, active-high): state=IDLE; busy=0, done=0, result=0, internal shift reg=0, count=0.
- States: IDLE, SHIFT.
- IDLE, start=1, flush=0: load reg<=operand, count<=shamt, op_r<=op; go to SHIFT; busy=1 from the next cycle.
- SHIFT, count!=0: reg<=one-step shift of reg per op_r, count<=count-1.
- SHIFT, count==0: result<=reg, done<=1 for exactly one cycle, state<=IDLE, busy<=0.
- Latency: start sampled at edge 0 -> done high in the cycle after edge shamt+1. shamt=0 -> done after edge 1 with result=operand.
- Step rules: SLL shifts in 0 at the LSB. SRL shifts in 0 at the MSB. SRA replicates the MSB.
- op=11: treated as shamt=0, so result=operand with normal done timing.
- start while busy: ignored. No queuing. operand/shamt are not re-sampled.
- start in the same cycle done is high: accepted, because state is already IDLE at that edge.
- flush in SHIFT: state<=IDLE, busy<=0, no done, result unchanged.
- flush together with start in IDLE: flush wins and the request is dropped.
- Reset asserted mid-operation: immediate return to reset values; no done.
- done and busy are never high in the same cycle.

Optional Feature:
SHIFT_SEQ_FAST4_EN
- Defined: in SHIFT with count>=4, shift by 4 and count<=count-4; otherwise step by 1. Latency becomes floor(shamt/4)+(shamt mod 4)+1 edges.
- Undefined: strictly 1 bit per cycle as specified above.
- Results are identical in both builds.

Decomposition:
- Package mips_shift_pkg: op encodings (OP_SLL, OP_SRL, OP_SRA, OP_RSVD) and the state enum (S_IDLE, S_SHIFT).
- Sub-module shift_step: combinational; inputs data, op, and a 1-or-4 amount select; output is the shifted data. Instantiated once.

Test Plan:
- SLL operand=0x0000000A, shamt=2 -> result=0x00000028, done after edge 3, busy high for 3 cycles.
- SRA operand=0x80000000, shamt=4 -> 0xF8000000. SRL with same inputs -> 0x08000000. shamt=31 SRA of 0x80000000 -> 0xFFFFFFFF.
- shamt=0 SLL operand=0x12345678 -> result=0x12345678, done after edge 1. op=11 gives the same result.
- start pulsed again mid-operation with operand=0xFFFFFFFF -> ignored, original result returned. Back-to-back start in the done cycle -> accepted.
- flush at the 2nd SHIFT cycle of shamt=10 -> busy drops next cycle, no done pulse, result keeps its prior value.
- reset asserted mid-operation (shamt=20) -> busy, done and result go to 0 immediately. A new SLL 1 by 1 afterwards -> 0x00000002.
